// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: next-PC arbitration, IF/ID/EXE PC pipeline and ISR entry/exit.
// Optional saturating statistics counters exist only when PC_SEQ_STATS_EN is defined.
module pc_sequencer #(
  parameter int unsigned     PC_W     = 11,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned     CNT_W    = 16
) (
  input  logic            CLK,
  input  logic            rst,
  input  logic            en,
  input  logic            stall,
  input  logic            if_is_comp,
  input  logic            if_prediction,
  input  logic [PC_W-1:0] if_PBT,
  input  logic            id_is_jump,
  input  logic            id_jump_in_bht,
  input  logic [PC_W-1:0] id_branchtarget,
  input  logic [1:0]      exe_correction,
  input  logic [PC_W-1:0] exe_PBT,
  input  logic [PC_W-1:0] exe_CNI,
  input  logic            int_req,
  input  logic [PC_W-1:0] int_vector,
  input  logic            mret,
  output logic [PC_W-1:0] if_PC,
  output logic [PC_W-1:0] id_PC,
  output logic [PC_W-1:0] exe_PC,
  output logic            id_valid,
  output logic            exe_valid,
  output logic            ISR_running,
  output logic [2:0]      sel_pc
`ifdef PC_SEQ_STATS_EN
  ,
  output logic [CNT_W-1:0] mispredict_cnt,
  output logic [CNT_W-1:0] id_redirect_cnt
`endif
);

  typedef enum logic {StRun, StIsr} state_e;

  state_e          r_state, w_state_d;
  logic [PC_W-1:0] r_if_pc, r_id_pc, r_exe_pc, r_ret_pc;
  logic [PC_W-1:0] w_next_pc, w_seq_pc;
  logic            r_id_valid, r_exe_valid, w_id_valid_d, w_exe_valid_d;
  logic            w_adv, w_mret_hit, w_exe_redir, w_isr_entry, w_id_redir, w_squash_all;
  logic [2:0]      w_sel;

  always_comb begin
    w_adv       = en && !stall;
    w_mret_hit  = (r_state == StIsr) && mret && r_exe_valid;
    w_exe_redir = w_mret_hit || (r_exe_valid && exe_correction[1]);
    // An EXE redirect defers ISR entry; entry is retried on the corrected stream.
    w_isr_entry = (r_state == StRun) && int_req && !w_exe_redir;
    w_id_redir  = r_id_valid && id_is_jump && !id_jump_in_bht;
    w_seq_pc    = r_if_pc + (if_is_comp ? PC_W'(1) : PC_W'(2));

    if (w_isr_entry)                                  w_sel = 3'd4;
    else if (w_mret_hit)                              w_sel = 3'd5;
    else if (r_exe_valid && exe_correction == 2'b11)  w_sel = 3'd3;
    else if (r_exe_valid && exe_correction == 2'b10)  w_sel = 3'd2;
    else if (w_id_redir)                              w_sel = 3'd1;
    else if (if_prediction)                           w_sel = 3'd6;
    else                                              w_sel = 3'd0;

    w_next_pc = w_seq_pc;
    case (w_sel)
      3'd4:    w_next_pc = int_vector;
      3'd5:    w_next_pc = r_ret_pc;
      3'd3:    w_next_pc = exe_PBT;
      3'd2:    w_next_pc = exe_CNI;
      3'd1:    w_next_pc = id_branchtarget;
      3'd6:    w_next_pc = if_PBT;
      default: w_next_pc = w_seq_pc;
    endcase

    w_squash_all  = w_isr_entry || w_exe_redir;
    w_id_valid_d  = !(w_squash_all || (w_sel == 3'd1));
    w_exe_valid_d = !w_squash_all && r_id_valid;

    w_state_d = r_state;
    if (w_isr_entry)     w_state_d = StIsr;
    else if (w_mret_hit) w_state_d = StRun;
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_state     <= StRun;
      r_if_pc     <= RESET_PC;
      r_id_pc     <= '0;
      r_exe_pc    <= '0;
      r_ret_pc    <= '0;
      r_id_valid  <= 1'b0;
      r_exe_valid <= 1'b0;
    end else if (w_adv) begin
      r_state     <= w_state_d;
      r_if_pc     <= w_next_pc;
      r_id_pc     <= r_if_pc;
      r_exe_pc    <= r_id_pc;
      r_id_valid  <= w_id_valid_d;
      r_exe_valid <= w_exe_valid_d;
      if (w_isr_entry) r_ret_pc <= r_id_valid ? r_id_pc : r_if_pc;
    end
  end

  assign if_PC       = r_if_pc;
  assign id_PC       = r_id_pc;
  assign exe_PC      = r_exe_pc;
  assign id_valid    = r_id_valid;
  assign exe_valid   = r_exe_valid;
  assign ISR_running = (r_state == StIsr);
  assign sel_pc      = w_sel;

`ifdef PC_SEQ_STATS_EN
  logic [CNT_W-1:0] r_mis_cnt, r_idr_cnt;

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_mis_cnt <= '0;
      r_idr_cnt <= '0;
    end else if (w_adv) begin
      if ((w_sel == 3'd2 || w_sel == 3'd3) && r_mis_cnt != '1) r_mis_cnt <= r_mis_cnt + CNT_W'(1);
      if (w_sel == 3'd1 && r_idr_cnt != '1) r_idr_cnt <= r_idr_cnt + CNT_W'(1);
    end
  end

  assign mispredict_cnt  = r_mis_cnt;
  assign id_redirect_cnt = r_idr_cnt;
`endif

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Fetch-side consumer of the branch history table's prediction/correction outputs; owns the IF program counter and the PC copies carried to ID and EXE.
- Resolves next PC each cycle from: EXE corrections, ID jump redirects, IF predictions and sequential increment.
- Tracks per-stage valid bits so squashed slots become bubbles; runs ISR entry/exit and drives ISR_running back to the predictor.
- All PCs are halfword addresses.

Parameters:
- PC_W, 11, PC width in halfwords.
- RESET_PC, 11'h000, if_PC value after reset.
- CNT_W, 16, width of the optional statistics counters.

Ports:
- CLK  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  global enable; when 0, all state holds.
- stall  in  1  pipeline stall; when 1, all state holds.
- if_is_comp  in  1  instruction at if_PC is 16-bit.
- if_prediction  in  1  BHT predicts taken at IF.
- if_PBT  in  PC_W  BHT predicted target at IF.
- id_is_jump  in  1  ID holds a jump.
- id_jump_in_bht  in  1  ID jump already predicted at IF.
- id_branchtarget  in  PC_W  ID computed target.
- exe_correction  in  2  {redirect, use_PBT} from the BHT.
- exe_PBT  in  PC_W  EXE predicted target.
- exe_CNI  in  PC_W  EXE correct next instruction.
- int_req  in  1  level interrupt request.
- int_vector  in  PC_W  ISR entry address.
- mret  in  1  EXE retires an interrupt return (valid only when exe_valid).
- if_PC  out  PC_W  fetch PC.
- id_PC  out  PC_W  PC of the ID slot.
- exe_PC  out  PC_W  PC of the EXE slot.
- id_valid  out  1  ID slot holds a live instruction.
- exe_valid  out  1  EXE slot holds a live instruction.
- ISR_running  out  1  ISR in progress.
- sel_pc  out  3  next-PC source code, for observation.

Behaviour:
- Reset (async, rst=1):
  - if_PC=RESET_PC; id_PC=exe_PC=0.
  - id_valid=exe_valid=0; ISR_running=0; FSM=RUN; saved return PC=0.
- Advance rule: registers update on posedge CLK only when en && !stall. Otherwise everything holds, including FSM and sel_pc inputs; no redirect is lost.
- Next-PC priority (sel_pc):
  - 3'd4 = int_vector (FSM entry).
  - 3'd5 = saved return PC (mret && exe_valid).
  - 3'd3 = exe_PBT (exe_correction=2'b11, exe_valid).
  - 3'd2 = exe_CNI (exe_correction=2'b10, exe_valid).
  - 3'd1 = id_branchtarget (id_is_jump && !id_jump_in_bht && id_valid).
  - 3'd6 = if_PBT (if_prediction).
  - 3'd0 = if_PC + (if_is_comp ? 1 : 2).
- Arithmetic: modulo 2^PC_W; 11'h7FF+2 wraps to 11'h001.
- Pipeline move: id_PC<=if_PC; exe_PC<=id_PC.
- Squash rules:
  - EXE redirect (codes 2, 3, 5) or ISR entry: next id_valid=0 and next exe_valid=0.
  - ID redirect (code 1): next id_valid=0; exe_valid<=id_valid.
  - Otherwise: id_valid<=1; exe_valid<=id_valid.
- Latency: a correction presented in cycle N yields the new if_PC at N+1; the first live instruction reaches EXE at N+3.
- FSM states RUN, ISR. Transitions:
  - RUN→ISR when int_req && !ISR_running && no EXE redirect this cycle. On entry:
    - save return PC = id_PC if id_valid, else if_PC;
    - if_PC<=int_vector; squash ID/EXE; ISR_running<=1.
  - If an EXE redirect coincides with int_req, the redirect wins and entry is retried next cycle. The return PC is then taken from the corrected stream.
  - ISR→RUN on mret && exe_valid: if_PC<=saved return PC; squash; ISR_running<=0.
  - int_req is ignored while in ISR (no nesting).
  - mret in RUN is treated as a no-op (code 0 path).
- Simultaneous events: exe_correction beats ID jump beats IF prediction. An ID redirect in the same cycle as an EXE redirect is discarded.
- Reset mid-ISR returns to RUN immediately with ISR_running=0.

Optional Feature:
- Macro: PC_SEQ_STATS_EN.
- Defined: adds outputs mispredict_cnt[CNT_W] (advances on codes 2/3) and id_redirect_cnt[CNT_W] (advances on code 1).
  - Both counters saturate at all-ones.
  - Both clear on rst.
  - Both count only on advancing cycles.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset release, no branches, alternating if_is_comp=0/1 from 0 → if_PC sequence 0,2,3,5,6; id_valid=1 from cycle 2; exe_valid=1 from cycle 3.
- if_PC=0x010, if_prediction=1, if_PBT=0x040 → if_PC=0x040 next cycle; sel_pc=6; no squash.
- exe_correction=2'b10, exe_CNI=0x022, with id_is_jump=1, id_jump_in_bht=0 in the same cycle → if_PC=0x022; id_valid=exe_valid=0; sel_pc=2; ID target ignored.
- stall=1 for 3 cycles while exe_correction=2'b11, exe_PBT=0x100 → all outputs frozen; on release if_PC=0x100.
- int_req=1 with id_PC=0x030 valid, int_vector=0x400 → if_PC=0x400, ISR_running=1; later mret with exe_valid=1 → if_PC=0x030, ISR_running=0.
- if_PC=0x7FF, 32-bit instruction, no prediction → if_PC=0x001; with PC_SEQ_STATS_EN, two EXE corrections → mispredict_cnt=2.
